// File: rtl/exhaustive_stim_gen.sv
// Exhaustive N-bit pattern source: every output is registered, so one clock from start to the first pattern; start is ignored while RUN and there is no backpressure.
// With STIM_CHECK_EN defined, resp is compared with &stim on the last dwell cycle of each pattern and err_cnt counts the mismatches.
module exhaustive_stim_gen #(
    parameter int N     = 3,
    parameter int DWELL = 100
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         mode_gray,
    input  logic         loop_en,
    output logic [N-1:0] stim,
    output logic         stim_valid,
    output logic [N-1:0] pattern_idx,
    output logic         busy,
    output logic         done
`ifdef STIM_CHECK_EN
    ,
    input  logic         resp,
    output logic [15:0]  err_cnt
`endif
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [DW-1:0] DW_ONE     = DW'(1);
    localparam logic [N-1:0]  IDX_LAST   = '1;
    localparam logic [N-1:0]  IDX_ONE    = N'(1);

    logic [1:0]    state;
    logic [DW-1:0] dwell_cnt;
    logic          gray_q;
    logic          loop_q;
    logic          dwell_end;
    logic          launch;

    assign dwell_end = (dwell_cnt == DWELL_LAST);
    assign launch    = start && !abort && (state != S_RUN);

    function automatic logic [N-1:0] encode(input logic [N-1:0] idx, input logic gray);
        return gray ? (idx ^ (idx >> 1)) : idx;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            dwell_cnt   <= '0;
            pattern_idx <= '0;
            stim        <= '0;
            stim_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            gray_q      <= 1'b0;
            loop_q      <= 1'b0;
        end else if (abort) begin
            state       <= S_IDLE;
            dwell_cnt   <= '0;
            pattern_idx <= '0;
            stim        <= '0;
            stim_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (launch) begin
            // Pattern 0 encodes to 0 in both orders, so stim needs no encode here.
            state       <= S_RUN;
            dwell_cnt   <= '0;
            pattern_idx <= '0;
            stim        <= '0;
            stim_valid  <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            gray_q      <= mode_gray;
            loop_q      <= loop_en;
        end else if (state == S_RUN) begin
            if (!dwell_end) begin
                dwell_cnt <= dwell_cnt + DW_ONE;
            end else begin
                dwell_cnt <= '0;
                if (pattern_idx != IDX_LAST || loop_q) begin
                    // Index wraps modulo 2^N on its own when looping.
                    pattern_idx <= pattern_idx + IDX_ONE;
                    stim        <= encode(pattern_idx + IDX_ONE, gray_q);
                end else begin
                    state      <= S_DONE;
                    stim       <= '0;
                    stim_valid <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                end
            end
        end
    end

`ifdef STIM_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (launch) begin
            err_cnt <= '0;
        end else if (!abort && state == S_RUN && stim_valid && dwell_end &&
                     (resp != (&stim)) && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_exhaustive_stim_gen.sv
// Bench for exhaustive_stim_gen: two instances (N=3/DWELL=100, N=2/DWELL=1) against a timeline reference model.
module tb_exhaustive_stim_gen;
    localparam int NA = 3;
    localparam int DA = 100;
    localparam int NB = 2;
    localparam int DB = 1;
    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_DONE = 2;

    // Model state: phase plus cycles elapsed since the start edge.
    typedef struct {
        int phase;
        int t;
        bit gray;
        bit lp;
        int err;
    } mdl_t;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] start_v, abort_v, gray_v, loop_v, resp_sel;
    logic [NA-1:0] stim_a, idx_a;
    logic val_a, busy_a, done_a;
    logic [NB-1:0] stim_b, idx_b;
    logic val_b, busy_b, done_b;
    int n_vec = 0;
    int n_err = 0;
    mdl_t m [2];
    int nn [2] = '{NA, NB};
    int dd [2] = '{DA, DB};

    always #5 clk = ~clk;

`ifdef STIM_CHECK_EN
    logic resp_a, resp_b;
    logic [15:0] err_a, err_b;
    assign resp_a = resp_sel[0] & (&stim_a);
    assign resp_b = resp_sel[1] & (&stim_b);
`endif

    exhaustive_stim_gen #(.N(NA), .DWELL(DA)) dut_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]),
        .mode_gray(gray_v[0]), .loop_en(loop_v[0]), .stim(stim_a),
        .stim_valid(val_a), .pattern_idx(idx_a), .busy(busy_a), .done(done_a)
`ifdef STIM_CHECK_EN
        , .resp(resp_a), .err_cnt(err_a)
`endif
    );

    exhaustive_stim_gen #(.N(NB), .DWELL(DB)) dut_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]),
        .mode_gray(gray_v[1]), .loop_en(loop_v[1]), .stim(stim_b),
        .stim_valid(val_b), .pattern_idx(idx_b), .busy(busy_b), .done(done_b)
`ifdef STIM_CHECK_EN
        , .resp(resp_b), .err_cnt(err_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_idx(mdl_t s, int n, int dw);
        if (s.phase == P_RUN) return (s.t / dw) % (1 << n);
        if (s.phase == P_DONE) return (1 << n) - 1;
        return 0;
    endfunction

    function automatic int exp_stim(mdl_t s, int n, int dw);
        int i;
        if (s.phase != P_RUN) return 0;
        i = exp_idx(s, n, dw);
        return s.gray ? (i ^ (i >> 1)) : i;
    endfunction

    // {stim_valid, busy, done}
    function automatic int exp_flags(mdl_t s);
        if (s.phase == P_RUN) return 6;
        if (s.phase == P_DONE) return 1;
        return 0;
    endfunction

    function automatic mdl_t adv(mdl_t s, int n, int dw, bit st, bit ab, bit g, bit lp, bit rs);
        int cur;
        cur = exp_stim(s, n, dw);
        if (!ab && s.phase == P_RUN && (s.t % dw) == dw - 1 &&
            rs != (cur == (1 << n) - 1) && s.err < 65535)
            s.err++;
        if (ab) begin
            s.phase = P_IDLE;
            s.t = 0;
        end else if (s.phase != P_RUN) begin
            if (st) begin
                s.phase = P_RUN;
                s.t = 0;
                s.gray = g;
                s.lp = lp;
                s.err = 0;
            end
        end else begin
            s.t++;
            if (s.t == (1 << n) * dw) begin
                if (s.lp) s.t = 0;
                else s.phase = P_DONE;
            end
        end
        return s;
    endfunction

    task automatic compare_all();
        chk("a_stim",  32'(stim_a), exp_stim(m[0], NA, DA));
        chk("a_idx",   32'(idx_a),  exp_idx(m[0], NA, DA));
        chk("a_flags", 32'({val_a, busy_a, done_a}), exp_flags(m[0]));
        chk("b_stim",  32'(stim_b), exp_stim(m[1], NB, DB));
        chk("b_idx",   32'(idx_b),  exp_idx(m[1], NB, DB));
        chk("b_flags", 32'({val_b, busy_b, done_b}), exp_flags(m[1]));
`ifdef STIM_CHECK_EN
        chk("a_err", 32'(err_a), m[0].err);
        chk("b_err", 32'(err_b), m[1].err);
`endif
    endtask

    task automatic cyc();
        for (int k = 0; k < 2; k++) begin
            int s;
            bit rs;
            s  = exp_stim(m[k], nn[k], dd[k]);
            rs = resp_sel[k] && (s == (1 << nn[k]) - 1);
            m[k] = adv(m[k], nn[k], dd[k], start_v[k], abort_v[k], gray_v[k], loop_v[k], rs);
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        int vcnt;
        rst = 1'b1;
        start_v = '0; abort_v = '0; gray_v = '0; loop_v = '0; resp_sel = 2'b11;
        m[0] = '{default: 0};
        m[1] = '{default: 0};
        #12 rst = 1'b0;
        #1 compare_all();

        // Binary non-loop run on a; looping run on b.
        start_v = 2'b11; gray_v = 2'b00; loop_v = 2'b10;
        cyc();
        start_v = 2'b00;
        vcnt = val_a ? 1 : 0;
        repeat (805) begin
            cyc();
            if (val_a) vcnt++;
        end
        chk("a_valid_len", vcnt, 800);
        chk("b_still_busy", 32'(busy_b), 1);

        // Abort the looping instance.
        abort_v = 2'b10;
        cyc();
        abort_v = 2'b00;
        chk("b_abort_stim", 32'(stim_b), 0);

        // Gray run from DONE with resp tied low on a.
        resp_sel[0] = 1'b0;
        gray_v[0] = 1'b1; start_v[0] = 1'b1;
        cyc();
        start_v[0] = 1'b0;
        repeat (802) cyc();
        chk("a_done_gray", 32'(done_a), 1);
`ifdef STIM_CHECK_EN
        chk("a_err_tie0", 32'(err_a), 1);
`endif

        // Start and abort together while DONE.
        start_v[0] = 1'b1; abort_v[0] = 1'b1;
        cyc();
        start_v[0] = 1'b0; abort_v[0] = 1'b0;
        cyc();

        // Restart, then asynchronous reset in the middle of pattern 5.
        resp_sel[0] = 1'b1; gray_v[0] = 1'b0;
        start_v[0] = 1'b1;
        cyc();
        start_v[0] = 1'b0;
        repeat (537) cyc();
        chk("a_idx_before_rst", 32'(idx_a), 5);
        #3 rst = 1'b1;
        #1;
        m[0] = '{default: 0};
        m[1] = '{default: 0};
        compare_all();
        #2 rst = 1'b0;

        // Random control traffic on both instances.
        repeat (2000) begin
            for (int k = 0; k < 2; k++) begin
                start_v[k] = ($urandom_range(15, 0) == 0);
                abort_v[k] = ($urandom_range(99, 0) == 0);
                gray_v[k]  = 1'($urandom_range(1, 0));
                loop_v[k]  = 1'($urandom_range(1, 0));
                if ($urandom_range(49, 0) == 0) resp_sel[k] = ~resp_sel[k];
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
